// File: rtl/bus_6502_responder_if.sv
// Signal bundle between the 6502 core, its bus responder and the memory port.
// The responder takes the slave side; the core/memory side takes the master side.
interface bus_6502_responder_if;
   logic        phi;
   logic        cpu_res;
   logic [15:0] ab;
   logic        rw;
   logic [7:0]  dbo;
   logic [7:0]  dbi;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_io;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport slave (
      output phi, cpu_res, dbi, mem_addr, mem_rd, mem_wr, mem_io, mem_wdata,
      input  ab, rw, dbo, mem_rdata, mem_ack
   );

   modport master (
      input  phi, cpu_res, dbi, mem_addr, mem_rd, mem_wr, mem_io, mem_wdata,
      output ab, rw, dbo, mem_rdata, mem_ack
   );
endinterface

// File: rtl/bus_6502_responder.sv
// Bus responder for the gate-level 6502: generates phi, holds the core in reset,
// and turns each phi2 into one memory request, stretching phi2 until it is acknowledged.
module bus_6502_responder #(
   parameter int          HALF_PERIOD  = 8,
   parameter int          RESET_CYCLES = 8,
   parameter logic [15:0] IO_BASE      = 16'hC000,
   parameter logic [15:0] IO_MASK      = 16'hFF00
) (
   input logic                 clk,
   input logic                 res,
   bus_6502_responder_if.slave bus
);

   localparam int               CNT_W    = $clog2(HALF_PERIOD) + 1;
   localparam int               RST_W    = $clog2(RESET_CYCLES + 1) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] WR_SLOT  = CNT_W'(HALF_PERIOD - 2);
   localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
   localparam logic [RST_W-1:0] RST_INIT = RST_W'(RESET_CYCLES);

   typedef enum logic [1:0] {PH1, PH2_REQ, PH2_RUN, PH2_WAIT} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [RST_W-1:0] rst_cnt, rst_cnt_n;
   logic             phi_q;
   logic             cpu_res_q, cpu_res_n;
   logic [7:0]       dbi_q, dbi_n;
   logic [15:0]      addr_q, addr_n;
   logic             io_q, io_n;
   logic [7:0]       wdata_q, wdata_n;
   logic             rd_q, rd_n;
   logic             wr_q, wr_n;
   logic             is_rd, is_rd_n;
   logic             pend, pend_n;
   logic             ack_rd, ack_wr, phi_fall;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state     <= PH1;
         cnt       <= '0;
         rst_cnt   <= RST_INIT;
         phi_q     <= 1'b0;
         cpu_res_q <= 1'b0;
         dbi_q     <= 8'hFF;
         addr_q    <= '0;
         io_q      <= 1'b0;
         wdata_q   <= '0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         is_rd     <= 1'b0;
         pend      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         rst_cnt   <= rst_cnt_n;
         phi_q     <= (state_n != PH1);
         cpu_res_q <= cpu_res_n;
         dbi_q     <= dbi_n;
         addr_q    <= addr_n;
         io_q      <= io_n;
         wdata_q   <= wdata_n;
         rd_q      <= rd_n;
         wr_q      <= wr_n;
         is_rd     <= is_rd_n;
         pend      <= pend_n;
      end
   end

   // Outputs are registered from next-state values, so a request pulse and its
   // address/data appear together in the same clk.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rst_cnt_n = rst_cnt;
      cpu_res_n = cpu_res_q;
      dbi_n     = dbi_q;
      addr_n    = addr_q;
      io_n      = io_q;
      wdata_n   = wdata_q;
      rd_n      = 1'b0;
      wr_n      = 1'b0;
      is_rd_n   = is_rd;
      pend_n    = pend;
      phi_fall  = 1'b0;

      // Write acks count only once phi2 is stretched, i.e. never in the mem_wr clk.
      ack_rd = bus.mem_ack && pend && is_rd && (state == PH2_RUN || state == PH2_WAIT);
      ack_wr = bus.mem_ack && pend && !is_rd && (state == PH2_WAIT);
      if (ack_rd) dbi_n = bus.mem_rdata;
      if (ack_rd || ack_wr) pend_n = 1'b0;

      case (state)
         PH1: begin
            if (cnt == PH_LAST) begin
               state_n = PH2_REQ;
               cnt_n   = '0;
               addr_n  = bus.ab;
               io_n    = ((bus.ab & IO_MASK) == IO_BASE);
               is_rd_n = bus.rw;
               rd_n    = bus.rw;
               pend_n  = bus.rw;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         PH2_REQ: begin
            state_n = PH2_RUN;
            cnt_n   = CNT_ONE;
         end
         PH2_RUN: begin
            if (cnt == PH_LAST) begin
               if (pend_n) begin
                  state_n = PH2_WAIT;
               end else begin
                  state_n  = PH1;
                  cnt_n    = '0;
                  phi_fall = 1'b1;
               end
            end else begin
               cnt_n = cnt + CNT_ONE;
               if (cnt == WR_SLOT && !is_rd) begin
                  wr_n    = 1'b1;
                  wdata_n = bus.dbo;
                  pend_n  = 1'b1;
               end
            end
         end
         PH2_WAIT: begin
            if (ack_rd || ack_wr) begin
               state_n  = PH1;
               cnt_n    = '0;
               phi_fall = 1'b1;
            end
         end
         default: state_n = PH1;
      endcase

      if (!cpu_res_q) begin
         if (rst_cnt == '0) begin
            cpu_res_n = 1'b1;
         end else if (phi_fall) begin
            rst_cnt_n = rst_cnt - RST_ONE;
            if (rst_cnt == RST_ONE) cpu_res_n = 1'b1;
         end
      end
   end

   assign bus.phi       = phi_q;
   assign bus.cpu_res   = cpu_res_q;
   assign bus.dbi       = dbi_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_io    = io_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_wr    = wr_q;

endmodule

// File: tb/tb_bus_6502_responder.sv
// Directed bench for bus_6502_responder: a bus-cycle timeline model predicts every
// output each clk, and a few literal expectations pin that model.
module tb_bus_6502_responder;
   localparam int          HP  = 4;
   localparam int          RC  = 2;
   localparam logic [15:0] IOB = 16'hC000;
   localparam logic [15:0] IOM = 16'hFF00;

   logic clk;
   logic res;

   bus_6502_responder_if bus ();

   bus_6502_responder #(
      .HALF_PERIOD (HP),
      .RESET_CYCLES(RC),
      .IO_BASE     (IOB),
      .IO_MASK     (IOM)
   ) dut (
      .clk(clk),
      .res(res),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int tclk     = 0;
   bit chk_en   = 1'b0;

   logic [7:0]  m_dbi, m_wdata, dbi_val;
   logic [15:0] m_addr;
   logic        m_io;
   int          falls, dbi_at;
   bit          first_cyc, dbi_sched;
   logic        exp_phi, exp_cres, exp_rd, exp_wr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_clk();
      @(posedge clk);
      #1;
      tclk++;
   endtask

   task automatic model_reset();
      m_dbi     = 8'hFF;
      m_wdata   = 8'h00;
      m_addr    = 16'h0000;
      m_io      = 1'b0;
      falls     = 0;
      first_cyc = 1'b1;
      dbi_sched = 1'b0;
      exp_phi   = 1'b0;
      exp_cres  = 1'b0;
      exp_rd    = 1'b0;
      exp_wr    = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("phi",           32'(bus.phi),                 32'(exp_phi));
         check("cpu_res",       32'(bus.cpu_res),             32'(exp_cres));
         check("dbi",           32'(bus.dbi),                 32'(m_dbi));
         check("mem_rd",        32'(bus.mem_rd),              32'(exp_rd));
         check("mem_wr",        32'(bus.mem_wr),              32'(exp_wr));
         check("mem_addr",      32'(bus.mem_addr),            32'(m_addr));
         check("mem_io",        32'(bus.mem_io),              32'(m_io));
         check("mem_wdata",     32'(bus.mem_wdata),           32'(m_wdata));
         check("rd_wr_overlap", 32'(bus.mem_rd & bus.mem_wr), 32'h0);
      end
   end

   task automatic do_abort();
      res          = 1'b0;
      bus.mem_ack  = 1'b0;
      #1;
      model_reset();
      check("abort_phi",     32'(bus.phi),       32'h0);
      check("abort_cpu_res", 32'(bus.cpu_res),   32'h0);
      check("abort_dbi",     32'(bus.dbi),       32'hFF);
      check("abort_addr",    32'(bus.mem_addr),  32'h0);
      check("abort_rd",      32'(bus.mem_rd),    32'h0);
      check("abort_io",      32'(bus.mem_io),    32'h0);
      do_clk();
      do_clk();
      res = 1'b1;
   endtask

   // One complete bus cycle: phi1 of HP clks, then phi2 whose length follows from the ack latency.
   task automatic run_cycle(input logic [15:0] a, input logic r, input logic [7:0] d,
                            input logic [7:0] rdat, input int lat, input bit ack_on_wr,
                            input bit stray, input int abort_k,
                            output int hi, output int nrd, output int nwr,
                            output logic [15:0] oaddr, output logic oio, output logic [7:0] owd);
      int p2len, total;
      hi = 0; nrd = 0; nwr = 0; oaddr = '0; oio = 1'b0; owd = '0;
      p2len = r ? ((lat + 1 > HP) ? lat + 1 : HP) : HP + lat;
      total = HP + p2len;
      if (!first_cyc) falls++;
      first_cyc = 1'b0;
      for (int k = 0; k < total; k++) begin
         if (dbi_sched && tclk >= dbi_at) begin
            m_dbi     = dbi_val;
            dbi_sched = 1'b0;
         end
         if (bus.phi) hi++;
         if (bus.mem_rd) begin nrd++; oaddr = bus.mem_addr; oio = bus.mem_io; end
         if (bus.mem_wr) begin nwr++; oaddr = bus.mem_addr; oio = bus.mem_io; owd = bus.mem_wdata; end
         if (k == abort_k) begin
            do_abort();
            return;
         end
         bus.ab        = a;
         bus.rw        = r;
         bus.dbo       = (k == 2*HP - 2) ? d : (d ^ 8'(k + 1));
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 8'(tclk);
         if (r && k == HP + lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdat;
            dbi_sched     = 1'b1;
            dbi_at        = tclk + 1;
            dbi_val       = rdat;
         end
         if (!r && (k == 2*HP - 1 + lat || (ack_on_wr && k == 2*HP - 1))) bus.mem_ack = 1'b1;
         if (stray && k == 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 8'h77;
         end
         if (k == HP) begin
            m_addr = a;
            m_io   = ((a & IOM) == IOB);
         end
         if (!r && k == 2*HP - 1) m_wdata = d;
         exp_phi  = (k >= HP);
         exp_rd   = r && (k == HP);
         exp_wr   = !r && (k == 2*HP - 1);
         exp_cres = (falls >= RC);
         do_clk();
      end
   endtask

   int          hi, nrd, nwr, tot_hi, tot_rd, tot_wr;
   logic [15:0] oa;
   logic        oio;
   logic [7:0]  owd;

   initial begin
      res           = 1'b0;
      bus.ab        = 16'h0000;
      bus.rw        = 1'b1;
      bus.dbo       = 8'h00;
      bus.mem_rdata = 8'h00;
      bus.mem_ack   = 1'b0;
      model_reset();
      repeat (3) do_clk();
      chk_en = 1'b1;
      check("rst_phi",     32'(bus.phi),       32'h0);
      check("rst_cpu_res", 32'(bus.cpu_res),   32'h0);
      check("rst_dbi",     32'(bus.dbi),       32'hFF);
      check("rst_addr",    32'(bus.mem_addr),  32'h0);
      check("rst_wdata",   32'(bus.mem_wdata), 32'h0);
      do_clk();
      res = 1'b1;

      run_cycle(16'hFFFC, 1'b1, 8'h00, 8'h34, 1, 1'b0, 1'b0, -1, hi, nrd, nwr, oa, oio, owd);
      check("t1_rd_count", 32'(nrd), 32'd1);
      check("t1_addr",     32'(oa),  32'hFFFC);
      check("t1_io",       32'(oio), 32'h0);
      check("t1_phi_hi",   32'(hi),  32'd4);
      check("t1_dbi",      32'(bus.dbi), 32'h34);
      check("t1_cres_1st", 32'(bus.cpu_res), 32'h0);

      run_cycle(16'hFFFD, 1'b1, 8'h00, 8'h12, 2, 1'b0, 1'b0, -1, hi, nrd, nwr, oa, oio, owd);
      check("t1_cres_2nd", 32'(bus.cpu_res), 32'h1);
      check("t1_dbi2",     32'(bus.dbi), 32'h12);

      run_cycle(16'h1234, 1'b1, 8'h00, 8'h5A, 7, 1'b0, 1'b0, -1, hi, nrd, nwr, oa, oio, owd);
      check("stretch_phi_hi", 32'(hi), 32'd8);
      check("stretch_dbi",    32'(bus.dbi), 32'h5A);

      run_cycle(16'hC010, 1'b0, 8'hA5, 8'h00, 2, 1'b1, 1'b0, -1, hi, nrd, nwr, oa, oio, owd);
      check("wr_count",  32'(nwr), 32'd1);
      check("wr_no_rd",  32'(nrd), 32'd0);
      check("wr_wdata",  32'(owd), 32'hA5);
      check("wr_io",     32'(oio), 32'h1);
      check("wr_phi_hi", 32'(hi),  32'd6);
      check("wr_dbi",    32'(bus.dbi), 32'h5A);

      run_cycle(16'hC110, 1'b1, 8'h00, 8'h9C, 2, 1'b0, 1'b1, -1, hi, nrd, nwr, oa, oio, owd);
      check("io_out_addr", 32'(oa), 32'hC110);
      check("io_out_io",   32'(oio), 32'h0);
      check("io_out_dbi",  32'(bus.dbi), 32'h9C);

      run_cycle(16'h2000, 1'b1, 8'h00, 8'hEE, 10, 1'b0, 1'b0, HP + 6, hi, nrd, nwr, oa, oio, owd);

      run_cycle(16'h0400, 1'b0, 8'h3C, 8'h00, 1, 1'b0, 1'b1, -1, hi, nrd, nwr, oa, oio, owd);
      check("stray_dbi",   32'(bus.dbi), 32'hFF);
      check("post_cres_1", 32'(bus.cpu_res), 32'h0);
      check("post_wdata",  32'(owd), 32'h3C);

      tot_hi = 0; tot_rd = 0; tot_wr = 0;
      for (int i = 0; i < 16; i++) begin
         run_cycle(16'h0200 + 16'(i), 1'b1, 8'h00, 8'(i * 3 + 1), 1, 1'b0, 1'b0, -1,
                   hi, nrd, nwr, oa, oio, owd);
         tot_hi += hi; tot_rd += nrd; tot_wr += nwr;
         if (i == 0) check("post_cres_2", 32'(bus.cpu_res), 32'h1);
      end
      check("b2b_rd",     32'(tot_rd), 32'd16);
      check("b2b_wr",     32'(tot_wr), 32'd0);
      check("b2b_phi_hi", 32'(tot_hi), 32'd64);
      check("b2b_dbi",    32'(bus.dbi), 32'h2E);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
